// File: rtl/fifo_fwft_if.sv
// fifo_fwft_if: bus bundle for the first-word-fall-through FIFO.
//
// Handshake semantics, in one place:
//   write side: a word is taken on a rising edge when write_strobe is high and
//     space_available was high before that edge. write_strobe while full drops
//     the word and raises overflow.
//   read side: read_data is the head word whenever data_available is high. A
//     rising edge with read_strobe high acknowledges it and the next word falls
//     through. read_strobe while empty raises underflow.
//   flush wins over both sides in its cycle and raises no error.
//
// Modports:
//   master - the producer/consumer side that drives strobes and data
//   slave  - the FIFO side that drives status and read data
interface fifo_fwft_if #(
  parameter int WIDTH = 8,
  parameter int NUM   = 4
);
  logic             flush;
  logic [WIDTH-1:0] write_data;
  logic             write_strobe;
  logic             space_available;
  logic             almost_full;
  logic [WIDTH-1:0] read_data;
  logic             read_strobe;
  logic             data_available;
  logic             almost_empty;
  logic             overflow;
  logic             underflow;
  logic             clear_errors;
  logic [NUM:0]     write_ptr;
  logic [NUM:0]     read_ptr;
  logic [NUM:0]     count;

  modport master (
    output flush, write_data, write_strobe, read_strobe, clear_errors,
    input  space_available, almost_full, read_data, data_available,
           almost_empty, overflow, underflow, write_ptr, read_ptr, count
  );

  modport slave (
    input  flush, write_data, write_strobe, read_strobe, clear_errors,
    output space_available, almost_full, read_data, data_available,
           almost_empty, overflow, underflow, write_ptr, read_ptr, count
  );
endinterface

// File: rtl/fifo_fwft.sv
// fifo_fwft: single-clock first-word-fall-through FIFO with register storage.
//
// Ports:
//   clk    - single clock, all state updates on rising edge
//   reset  - asynchronous active-high, clears pointers, count and error flags
//   bus    - fifo_fwft_if.slave: write/read strobes and data, flush,
//            clear_errors, status flags, sticky errors, debug pointers, count
//
// Parameters:
//   WIDTH  - data word width
//   NUM    - log2 of depth
//   AFULL  - almost_full when count >= AFULL
//   AEMPTY - almost_empty when count <= AEMPTY
module fifo_fwft #(
  parameter int WIDTH  = 8,
  parameter int NUM    = 4,
  parameter int AFULL  = 14,
  parameter int AEMPTY = 2
) (
  input  logic        clk,
  input  logic        reset,
  fifo_fwft_if.slave  bus
);
  localparam int DEPTH = 2 ** NUM;
  localparam logic [NUM:0] DEPTH_C  = (NUM+1)'(DEPTH);
  localparam logic [NUM:0] AFULL_C  = (NUM+1)'(AFULL);
  localparam logic [NUM:0] AEMPTY_C = (NUM+1)'(AEMPTY);

  if (!(AEMPTY >= 1 && AEMPTY < AFULL && AFULL <= DEPTH - 1)) begin : g_bad_params
    $error("fifo_fwft: need 1 <= AEMPTY < AFULL <= 2**NUM-1");
  end

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [NUM:0]     r_wptr;
  logic [NUM:0]     r_rptr;
  logic [NUM:0]     r_count;
  logic             r_overflow;
  logic             r_underflow;

  logic w_space;
  logic w_avail;
  logic w_wr;
  logic w_rd;
  logic w_ovf_set;
  logic w_unf_set;

  // Status comes only from registered count, so strobes never reach status
  // combinationally. Full/empty tests are not relaxed by a concurrent op.
  assign w_space   = (r_count < DEPTH_C);
  assign w_avail   = (r_count != '0);
  assign w_wr      = bus.write_strobe & w_space & ~bus.flush;
  assign w_rd      = bus.read_strobe  & w_avail & ~bus.flush;
  assign w_ovf_set = bus.write_strobe & ~w_space & ~bus.flush;
  assign w_unf_set = bus.read_strobe  & ~w_avail & ~bus.flush;

  // Storage is deliberately not reset; read_data is gated when empty.
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wptr[NUM-1:0]] <= bus.write_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (bus.flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_wr) r_wptr <= r_wptr + 1'b1;
      if (w_rd) r_rptr <= r_rptr + 1'b1;
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // A new error in the same cycle as clear_errors keeps the flag set.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_ovf_set)             r_overflow <= 1'b1;
      else if (bus.clear_errors) r_overflow <= 1'b0;
      if (w_unf_set)             r_underflow <= 1'b1;
      else if (bus.clear_errors) r_underflow <= 1'b0;
    end
  end

  assign bus.space_available = w_space;
  assign bus.data_available  = w_avail;
  assign bus.almost_full     = (r_count >= AFULL_C);
  assign bus.almost_empty    = (r_count <= AEMPTY_C);
  assign bus.read_data       = w_avail ? r_mem[r_rptr[NUM-1:0]] : '0;
  assign bus.overflow        = r_overflow;
  assign bus.underflow       = r_underflow;
  assign bus.write_ptr       = r_wptr;
  assign bus.read_ptr        = r_rptr;
  assign bus.count           = r_count;
endmodule
